// File: rtl/inv_sub_bytes_iter.sv
// AES InvSubBytes over one 128-bit state, LANES bytes per cycle through shared inv_sbox lookups.
// Results are handed back over a valid/ready handshake.

module inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] TABLE [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = TABLE[in_byte];

endmodule

module inv_sub_bytes_iter #(
  parameter int BYTE     = 8,
  parameter int WORD     = 32,
  parameter int SENTENCE = 128,
  parameter int LANES    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SENTENCE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SENTENCE-1:0] out_data,
  output logic                busy
);

  localparam int CHUNK = BYTE * LANES;
  localparam int N     = SENTENCE / CHUNK;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;

  if (LANES < 1 || LANES > 16 || (16 % LANES) != 0 || SENTENCE != 4 * WORD || WORD != 4 * BYTE) begin : g_bad_cfg
    $error("inv_sub_bytes_iter: LANES must divide 16 and widths must match AES");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [SENTENCE-1:0] buffer;
  logic [CW-1:0]       cnt;
  logic                last;
  logic [CHUNK-1:0]    chunk_in;
  logic [CHUNK-1:0]    chunk_out;

  assign last     = (cnt == CW'(N - 1));
  assign out_data = buffer;

  // Pick the chunk addressed by cnt with constant slices so the select stays a plain mux.
  always_comb begin
    chunk_in = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) chunk_in = buffer[k*CHUNK +: CHUNK];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .in_byte (chunk_in[l*BYTE +: BYTE]),
      .out_byte(chunk_out[l*BYTE +: BYTE])
    );
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The buffer holds the state in place; each BUSY cycle overwrites one chunk with its substitution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            buffer <= in_data;
            cnt    <= '0;
          end
        end
        BUSY: begin
          for (int k = 0; k < N; k++) begin
            if (cnt == CW'(k)) buffer[k*CHUNK +: CHUNK] <= chunk_out;
          end
          if (!last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter: reset, known bytes, round trips, backpressure,
// mid-operation reset and back-to-back transfers.

module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [127:0] out_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] sbox_tab [256];

  inv_sub_bytes_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
      end
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [127:0] sub_model(input logic [127:0] st);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = sbox_tab[st[8*j +: 8]];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transfer: accept, count edges (accept edge included) until out_valid, then handshake.
  task automatic apply_stimulus(input string tag, input logic [127:0] data, input logic [127:0] exp);
    int edges;
    check_output({tag, " in_ready"}, 128'(in_ready), 128'(1));
    in_data   = data;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    check_output({tag, " latency"}, 128'(edges), 128'(5));
    check_output({tag, " data"}, out_data, exp);
    step();
    check_output({tag, " released"}, 128'({out_valid, in_ready}), 128'(2'b01));
  endtask

  logic [127:0] st_a, st_b, exp_a, exp_b, held;
  logic [127:0] res [2];
  logic         acc;
  logic         seen_valid;
  int           cyc, acc0, acc1, nres, edges;

  initial begin
    build_sbox();

    // Power-on reset, checked before any clock edge.
    #2;
    check_output("por", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    check_output("por data", out_data, '0);
    #10;
    rst_n = 1'b1;
    step();

    // Known bytes
    apply_stimulus("known", {{11{8'h63}}, 8'h16, 8'hed, 8'h00, 8'h7c, 8'h63},
                            {{11{8'h00}}, 8'hff, 8'h53, 8'h52, 8'h01, 8'h00});

    // Every byte value once, then random states, through the forward model
    for (int s = 0; s < 16; s++) begin
      for (int j = 0; j < 16; j++) st_a[8*j +: 8] = 8'(16 * s + j);
      apply_stimulus($sformatf("sweep%0d", s), sub_model(st_a), st_a);
    end
    for (int n = 0; n < 40; n++) begin
      st_a = {$urandom, $urandom, $urandom, $urandom};
      apply_stimulus($sformatf("rand%0d", n), sub_model(st_a), st_a);
    end

    // Asynchronous reset while results are held in DONE
    st_a = 128'h0123456789abcdef_fedcba9876543210;
    in_data = sub_model(st_a);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    check_output("pre-reset done", out_data, st_a);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async reset flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    check_output("async reset data", out_data, '0);
    #1;
    rst_n = 1'b1;
    step();

    // Backpressure with a competing input held valid
    st_a = 128'hdeadbeef_00112233_44556677_8899aabb;
    st_b = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    in_data = sub_model(st_a);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_data = sub_model(st_b);
    edges = 0;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    check_output("bp first data", out_data, st_a);
    held = out_data;
    for (int c = 0; c < 10; c++) begin
      step();
      check_output($sformatf("bp hold%0d", c), out_data, held);
      check_output($sformatf("bp ready%0d", c), 128'({in_ready, out_valid}), 128'(2'b01));
    end
    out_ready = 1'b1;
    step();
    check_output("bp handshake", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    step();
    in_valid = 1'b0;
    check_output("bp accept", 128'(busy), 128'(1));
    edges = 0;
    while (!out_valid && edges < 20) begin
      step();
      edges++;
    end
    check_output("bp second data", out_data, st_b);
    step();

    // Reset with cnt==2
    in_data = sub_model(st_a);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midop reset", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    #1;
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      seen_valid = seen_valid | out_valid;
    end
    check_output("midop no valid", 128'(seen_valid), 128'(0));
    apply_stimulus("after reset", sub_model(st_b), st_b);

    // Back-to-back with in_valid and out_ready held high
    st_a = 128'h00000000_00000000_00000000_000000ff;
    st_b = 128'h80706050_40302010_f0e0d0c0_b0a09000;
    in_data = sub_model(st_a);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc = 0; acc0 = -1; acc1 = -1; nres = 0;
    while (nres < 2 && cyc < 40) begin
      acc = in_valid && in_ready;
      step();
      cyc++;
      if (acc) begin
        if (acc0 < 0) begin
          acc0 = cyc;
          in_data = sub_model(st_b);
        end else begin
          acc1 = cyc;
          in_valid = 1'b0;
        end
      end
      if (out_valid && nres < 2) begin
        res[nres] = out_data;
        nres++;
      end
    end
    in_valid = 1'b0;
    check_output("b2b count", 128'(nres), 128'(2));
    check_output("b2b first", res[0], st_a);
    check_output("b2b second", res[1], st_b);
    check_output("b2b spacing", 128'(acc1 - acc0), 128'(6));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
